// File: rtl/calc_core.sv
// calc_core: arithmetic execution stage of the mini calculator.
// Add/sub finish in one EXEC cycle. Mul (shift-add) and div (restoring) iterate
// WIDTH steps in ITER. Define CALC_DIV_EN to build the divider. Without it,
// every divide completes as an error with add/sub timing.
module calc_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           btn_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 neg_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d, op_c;
    logic [3:0]         btn_q, btn_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [W2-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W2-1:0]      result_q, result_d;
    logic               neg_q, neg_d, err_q, err_d, busy_q, busy_d, done_q, done_d;
    logic               event_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [W2-1:0]      mul_step_c, step_c;

    // A new press or a direct operator change; priority bit3 > bit2 > bit1 > bit0.
    always_comb begin
        event_c = (btn_i != 4'b0000) && (btn_i != btn_q);
        op_c    = OP_DIV;
        if (btn_i[3])      op_c = OP_ADD;
        else if (btn_i[2]) op_c = OP_SUB;
        else if (btn_i[1]) op_c = OP_MUL;
    end

    // One shift-add step: {hi, multiplier} with hi += A when the multiplier LSB is set.
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : (WIDTH+1)'(0));
        mul_step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
    end

`ifdef CALC_DIV_EN
    logic [WIDTH:0]     div_shift_c, div_diff_c;
    logic [W2-1:0]      div_step_c;

    // One restoring step on {remainder, quotient}: shift left, trial subtract B.
    always_comb begin
        div_shift_c = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_c  = div_shift_c - {1'b0, b_q};
        if (!div_diff_c[WIDTH])
            div_step_c = {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            div_step_c = {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    // Select the iterative step matching the latched operator.
    always_comb step_c = (op_q == OP_MUL) ? mul_step_c : div_step_c;
`else
    // Only the multiplier iterates when the divider is not built.
    always_comb step_c = mul_step_c;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        btn_d    = btn_i;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        neg_d    = neg_q;
        err_d    = err_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (event_c) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    op_d  = op_c;
                    cnt_d = CW'(WIDTH);
                    unique case (op_c)
                        OP_MUL: begin
                            acc_d   = W2'(b_i);
                            state_d = ITER;
                        end
`ifdef CALC_DIV_EN
                        OP_DIV: begin
                            if (b_i == '0) begin
                                state_d = EXEC;
                            end else begin
                                acc_d   = W2'(a_i);
                                state_d = ITER;
                            end
                        end
`endif
                        default: state_d = EXEC;
                    endcase
                end
            end
            EXEC: begin
                neg_d   = 1'b0;
                err_d   = 1'b0;
                state_d = DONE;
                unique case (op_q)
                    OP_ADD: result_d = W2'(a_q) + W2'(b_q);
                    OP_SUB: begin
                        if (a_q >= b_q) begin
                            result_d = W2'(a_q - b_q);
                        end else begin
                            result_d = W2'(b_q - a_q);
                            neg_d    = 1'b1;
                        end
                    end
                    default: begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                endcase
            end
            ITER: begin
                acc_d = step_c;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = step_c;
                    neg_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ITER) || (state_d == DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            btn_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            btn_q    <= btn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign neg_o    = neg_q;
    assign err_o    = err_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule
